// File: rtl/mbist_mbisr_ctrl.sv
// March C- memory BIST engine with built-in self-repair: drives a single-port SRAM,
// compares read data and logs failing rows into a spare-row remap table.
module mbist_mbisr_ctrl #(
    parameter int AW      = 4,
    parameter int DW      = 8,
    parameter int SPARES  = 2,
    parameter int CHECKER = 0,
    localparam int SW     = $clog2(SPARES + 1),
    localparam int IW     = (SPARES > 1) ? $clog2(SPARES) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          fail,
    output logic [SW-1:0] spare_used,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic [AW-1:0] q_addr,
    output logic          q_hit,
    output logic [IW-1:0] q_idx
);

    typedef enum logic [3:0] {
        S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_FLUSH, S_DONE
    } state_t;

    function automatic logic [DW-1:0] chk_pattern();
        chk_pattern = '0;
        for (int i = 0; i < DW; i++) chk_pattern[i] = ~i[0];
    endfunction

    localparam logic [DW-1:0] CHK_BG = chk_pattern();

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          phase_q, phase_d;  // 0 = read slot, 1 = write slot of an r,w element
    logic          pass_q, pass_d;    // 1 = checkerboard background pass
    logic          clear;

    logic          rd_pend_q;
    logic [AW-1:0] rd_addr_q;
    logic [DW-1:0] rd_exp_q;
    logic          fail_q;
    logic [SW-1:0] used_q;
    logic [AW-1:0] tbl_q [SPARES];

    logic [DW-1:0] zero_v, one_v, exp_v;
    logic          is_rw, desc, step, last;
    logic          log_hit, mismatch, log_new;

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        phase_d   = phase_q;
        pass_d    = pass_q;
        clear     = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        exp_v     = '0;
        zero_v    = pass_q ? CHK_BG : '0;
        one_v     = ~zero_v;
        is_rw     = state_q inside {S_M1, S_M2, S_M3, S_M4};
        desc      = state_q inside {S_M3, S_M4};
        step      = !is_rw || phase_q;
        last      = desc ? (addr_q == '0) : (addr_q == '1);

        case (state_q)
            S_IDLE, S_DONE: if (start) begin
                state_d = S_M0;
                addr_d  = '0;
                phase_d = 1'b0;
                pass_d  = 1'b0;
                clear   = 1'b1;
            end
            S_M0:    begin mem_en = 1'b1; mem_we = 1'b1;    mem_wdata = zero_v; end
            S_M1:    begin mem_en = 1'b1; mem_we = phase_q; mem_wdata = one_v;  exp_v = zero_v; end
            S_M2:    begin mem_en = 1'b1; mem_we = phase_q; mem_wdata = zero_v; exp_v = one_v;  end
            S_M3:    begin mem_en = 1'b1; mem_we = phase_q; mem_wdata = one_v;  exp_v = zero_v; end
            S_M4:    begin mem_en = 1'b1; mem_we = phase_q; mem_wdata = zero_v; exp_v = one_v;  end
            S_M5:    begin mem_en = 1'b1;                                       exp_v = zero_v; end
            S_FLUSH: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase

        if (is_rw) phase_d = ~phase_q;

        if (mem_en && step) begin
            if (last) begin
                // M3 and M4 walk downwards and start from the top row.
                addr_d = (state_q == S_M2 || state_q == S_M3) ? '1 : '0;
                case (state_q)
                    S_M0:    state_d = S_M1;
                    S_M1:    state_d = S_M2;
                    S_M2:    state_d = S_M3;
                    S_M3:    state_d = S_M4;
                    S_M4:    state_d = S_M5;
                    default: begin
                        if (CHECKER != 0 && !pass_q) begin
                            state_d = S_M0;
                            pass_d  = 1'b1;
                        end else begin
                            state_d = S_FLUSH;
                        end
                    end
                endcase
            end else begin
                addr_d = desc ? addr_q - 1'b1 : addr_q + 1'b1;
            end
        end
    end

    assign mem_addr   = addr_q;
    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done       = (state_q == S_DONE);
    assign fail       = fail_q;
    assign spare_used = used_q;

    // Entry i is valid exactly when i < spare_used; descending scan lets the lowest index win.
    always_comb begin
        q_hit   = 1'b0;
        q_idx   = '0;
        log_hit = 1'b0;
        for (int i = SPARES - 1; i >= 0; i--) begin
            if (SW'(i) < used_q && tbl_q[i] == q_addr) begin
                q_hit = 1'b1;
                q_idx = IW'(i);
            end
            if (SW'(i) < used_q && tbl_q[i] == rd_addr_q) log_hit = 1'b1;
        end
    end

    assign mismatch = rd_pend_q && (mem_rdata != rd_exp_q) && !log_hit && !clear;
    assign log_new  = mismatch && (used_q < SW'(SPARES));

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            phase_q <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            phase_q <= phase_d;
            pass_q  <= pass_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_q <= 1'b0;
            rd_addr_q <= '0;
            rd_exp_q  <= '0;
            fail_q    <= 1'b0;
            used_q    <= '0;
        end else begin
            rd_pend_q <= mem_en && !mem_we;
            rd_addr_q <= addr_q;
            rd_exp_q  <= exp_v;
            if (clear) begin
                fail_q <= 1'b0;
                used_q <= '0;
            end else if (log_new) begin
                used_q <= used_q + 1'b1;
            end else if (mismatch) begin
                fail_q <= 1'b1;
            end
        end
    end

    // NOTE: the table storage needs no reset; spare_used = 0 already marks every entry invalid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < SPARES; i++) begin
            if (log_new && SW'(i) == used_q) tbl_q[i] <= rd_addr_q;
        end
    end

endmodule

// File: doc/mbist_mbisr_ctrl.md
Name: mbist_mbisr_ctrl

Overview:
Parametrised next-generation March C- memory BIST engine with built-in self-repair (MBISR).
- Drives an external single-port synchronous SRAM through a simple enable/write port.
- Compares read data against the expected pattern.
- Logs failing addresses into a spare-row remap table.
- Exposes a combinational remap lookup for the functional datapath.
- Sits between the chip top-level wrapper (start/done/fail pins) and the memory macro.

Parameters:
- AW, 4, memory address width; DEPTH = 2^AW words.
- DW, 8, memory data width.
- SPARES, 2, number of spare-row remap entries (1..8).
- CHECKER, 0, 1 = after the solid pass, run a second full March C- pass with checkerboard background (0x55.. / 0xAA..).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level; sampled only in IDLE/DONE; rising of test begins next cycle.
- busy  out  1  high while test runs.
- done  out  1  sticky high after test completes until next accepted start.
- fail  out  1  sticky high if failures exceed SPARES (unrepairable); valid when done=1.
- spare_used  out  $clog2(SPARES+1)  number of remap entries filled.
- mem_en  out  1  memory access enable.
- mem_we  out  1  1 = write, 0 = read (meaningful when mem_en=1).
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  write data.
- mem_rdata  in  DW  read data, valid exactly one cycle after a read issue.
- q_addr  in  AW  functional address to look up.
- q_hit  out  1  combinational: q_addr matches a valid remap entry.
- q_idx  out  $clog2(SPARES) (min 1)  index of matching entry; 0 when no hit.

Behaviour:
Reset values (asynchronous, on rst_n low):
- busy = done = fail = 0, spare_used = 0, all remap entries invalid.
- mem_en = mem_we = 0, mem_addr = 0, mem_wdata = 0, state IDLE.
- Reset mid-test aborts immediately with the same values.

States: IDLE, M0..M5, FLUSH, DONE.
- M0 ⇑(w0)
- M1 ⇑(r0,w1)
- M2 ⇑(r1,w0)
- M3 ⇓(r0,w1)
- M4 ⇓(r1,w0)
- M5 ⇑(r0)
- "0" = background B, "1" = ~B. Pass 1 uses B = all-zeros. When CHECKER=1, pass 2 uses B = 0x55.. repeating and runs M0..M5 again before FLUSH.

Start handling:
- start=1 in IDLE or DONE clears done, fail, spare_used and the remap table.
- busy goes high the next cycle and the M0 write to address 0 is issued that same cycle.
- start is ignored while busy.

Access timing:
- One memory op per cycle.
- r,w elements take 2 cycles per address: read at t, write at t+1.
- Single-op elements take 1 cycle per address.
- Ascending elements run address 0..DEPTH-1; descending elements run DEPTH-1..0. The address counter wraps without overflow.

Compare:
- mem_rdata is compared in the cycle after each read issue, including across element boundaries.
- FLUSH is one cycle with mem_en=0 to compare the final M5 read.
- Pass length is 10*DEPTH op cycles. busy falls and done rises on the cycle after FLUSH, i.e. 10*DEPTH+2 cycles after start is sampled (20*DEPTH+2 when CHECKER=1).

Repair logging on a mismatch at address A:
- A already in table: no change.
- Else if spare_used < SPARES: store A in entry spare_used, then increment spare_used.
- Else: set fail (sticky).
- The test always runs to completion regardless of failures.

Remap lookup:
- Purely combinational.
- Entries are unique, so at most one hit; if there were several, the lowest index wins.

Outcomes at done:
- fail=0, spare_used=0: clean.
- fail=0, spare_used>0: repaired.
- fail=1: unrepairable.

Test Plan:
1. AW=4, DW=8, fault-free behavioural SRAM, start pulsed 1 cycle -> done=1 exactly 162 cycles later, fail=0, spare_used=0; op trace matches 160 March C- ops with M3/M4 addresses descending 15..0.
2. Bit 3 of addr 5 stuck-at-0 -> done=1, fail=0, spare_used=1; q_addr=5 gives q_hit=1, q_idx=0; q_addr=6 gives q_hit=0.
3. SPARES=2, stuck faults at addrs 2, 9, 14 -> table holds 2 then 9, spare_used=2, fail=1, done at the same cycle as scenario 1.
4. Coupling fault (write 1 to addr 7 flips addr 3) -> addr 3 logged once despite multiple mismatches, spare_used=1.
5. Assert rst_n=0 mid-M2 -> outputs immediately reset values; new start yields full clean 162-cycle run. Re-start from DONE after scenario 3 clears fail and spare_used.
6. CHECKER=1, fault-free -> done after 322 cycles; pass-2 M0 mem_wdata=0x55, M1 write data=0xAA.
